// File: rtl/picorv32_bus_pkg.sv
// Shared types and default memory-map constants for the PicoRV32 bus router.
package picorv32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SRAM_REQ,
        MMIO_REQ,
        DONE
    } state_t;

    localparam logic [31:0] SRAM_BASE_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] SRAM_SIZE_DEFAULT = 32'h0001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;
    localparam logic [31:0] MMIO_SIZE_DEFAULT = 32'h0000_1000;

    localparam int unsigned SRAM_OFF_W = 17;
    localparam int unsigned MMIO_OFF_W = 12;

endpackage

// File: rtl/picorv32_addr_decode.sv
// Combinational window decode: classifies a CPU address and derives target byte offsets.
module picorv32_addr_decode
    import picorv32_bus_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE = SRAM_BASE_DEFAULT,
    parameter logic [31:0] SRAM_SIZE = SRAM_SIZE_DEFAULT,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEFAULT
) (
    input  logic [31:0]           addr,
    output logic                  hit_sram,
    output logic                  hit_mmio,
    output logic [SRAM_OFF_W-1:0] sram_off,
    output logic [MMIO_OFF_W-1:0] mmio_off
);

    logic [31:0] sram_diff;
    logic [31:0] mmio_diff;

    // The lower-bound test guards against wrap-around of the unsigned difference.
    always_comb begin
        sram_diff = addr - SRAM_BASE;
        mmio_diff = addr - MMIO_BASE;
        hit_sram  = (addr >= SRAM_BASE) && (sram_diff < SRAM_SIZE);
        hit_mmio  = (addr >= MMIO_BASE) && (mmio_diff < MMIO_SIZE);
        sram_off  = sram_diff[SRAM_OFF_W-1:0];
        mmio_off  = mmio_diff[MMIO_OFF_W-1:0];
    end

endmodule

// File: rtl/picorv32_bus_router.sv
// Routes PicoRV32 native-bus transactions to SRAM or MMIO, with timeout and unmapped-access errors.
module picorv32_bus_router
    import picorv32_bus_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE      = SRAM_BASE_DEFAULT,
    parameter logic [31:0] SRAM_SIZE      = SRAM_SIZE_DEFAULT,
    parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
    parameter logic [31:0] MMIO_SIZE      = MMIO_SIZE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  cpu_mem_valid,
    input  logic                  cpu_mem_instr,
    input  logic [31:0]           cpu_mem_addr,
    input  logic [31:0]           cpu_mem_wdata,
    input  logic [3:0]            cpu_mem_wstrb,
    output logic                  cpu_mem_ready,
    output logic [31:0]           cpu_mem_rdata,

    output logic                  sram_mem_valid,
    output logic                  sram_mem_instr,
    output logic [SRAM_OFF_W-1:0] sram_mem_addr,
    output logic [31:0]           sram_mem_wdata,
    output logic [3:0]            sram_mem_wstrb,
    input  logic                  sram_mem_ready,
    input  logic [31:0]           sram_mem_rdata,

    output logic                  mmio_valid,
    output logic [MMIO_OFF_W-1:0] mmio_addr,
    output logic [31:0]           mmio_wdata,
    output logic [3:0]            mmio_wstrb,
    input  logic                  mmio_ready,
    input  logic [31:0]           mmio_rdata,

    output logic                  bus_err,
    output logic [31:0]           err_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t                state;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  instr_q;
    logic [SRAM_OFF_W-1:0] sram_off_q;
    logic [MMIO_OFF_W-1:0] mmio_off_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  sram_valid_q;
    logic                  mmio_valid_q;

    logic                  hit_sram;
    logic                  hit_mmio;
    logic [SRAM_OFF_W-1:0] dec_sram_off;
    logic [MMIO_OFF_W-1:0] dec_mmio_off;

    logic                  tgt_valid;
    logic                  tgt_ready;
    logic [31:0]           tgt_rdata;

    picorv32_addr_decode #(
        .SRAM_BASE (SRAM_BASE),
        .SRAM_SIZE (SRAM_SIZE),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_SIZE (MMIO_SIZE)
    ) u_decode (
        .addr     (cpu_mem_addr),
        .hit_sram (hit_sram),
        .hit_mmio (hit_mmio),
        .sram_off (dec_sram_off),
        .mmio_off (dec_mmio_off)
    );

    // Both request states share one handshake path; pick the active target's view.
    always_comb begin
        tgt_valid = sram_valid_q | mmio_valid_q;
        tgt_ready = 1'b0;
        tgt_rdata = '0;
        if (state == SRAM_REQ) begin
            tgt_ready = sram_mem_ready;
            tgt_rdata = sram_mem_rdata;
        end else if (state == MMIO_REQ) begin
            tgt_ready = mmio_ready;
            tgt_rdata = mmio_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            instr_q       <= 1'b0;
            sram_off_q    <= '0;
            mmio_off_q    <= '0;
            wait_cnt      <= '0;
            sram_valid_q  <= 1'b0;
            mmio_valid_q  <= 1'b0;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= '0;
            bus_err       <= 1'b0;
            err_addr      <= '0;
        end else begin
            cpu_mem_ready <= 1'b0;
            bus_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_mem_valid && !cpu_mem_ready) begin
                        addr_q     <= cpu_mem_addr;
                        wdata_q    <= cpu_mem_wdata;
                        wstrb_q    <= cpu_mem_wstrb;
                        instr_q    <= cpu_mem_instr;
                        sram_off_q <= dec_sram_off;
                        mmio_off_q <= dec_mmio_off;
                        wait_cnt   <= '0;
                        if (hit_sram) begin
                            state <= SRAM_REQ;
                        end else if (hit_mmio) begin
                            state <= MMIO_REQ;
                        end else begin
                            state         <= DONE;
                            cpu_mem_ready <= 1'b1;
                            cpu_mem_rdata <= '0;
                            bus_err       <= 1'b1;
                            err_addr      <= cpu_mem_addr;
                        end
                    end
                end
                SRAM_REQ, MMIO_REQ: begin
                    // A ready still high from the previous access holds valid off until it drops.
                    if (tgt_valid && tgt_ready) begin
                        sram_valid_q  <= 1'b0;
                        mmio_valid_q  <= 1'b0;
                        cpu_mem_rdata <= tgt_rdata;
                        cpu_mem_ready <= 1'b1;
                        state         <= DONE;
                    end else if (!tgt_ready) begin
                        if (wait_cnt == CNT_MAX) begin
                            sram_valid_q  <= 1'b0;
                            mmio_valid_q  <= 1'b0;
                            cpu_mem_rdata <= '0;
                            cpu_mem_ready <= 1'b1;
                            bus_err       <= 1'b1;
                            err_addr      <= addr_q;
                            state         <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                            if (state == SRAM_REQ) begin
                                sram_valid_q <= 1'b1;
                            end else begin
                                mmio_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sram_mem_valid = sram_valid_q;
    assign sram_mem_instr = instr_q;
    assign sram_mem_addr  = sram_off_q;
    assign sram_mem_wdata = wdata_q;
    assign sram_mem_wstrb = wstrb_q;

    assign mmio_valid     = mmio_valid_q;
    assign mmio_addr      = mmio_off_q;
    assign mmio_wdata     = wdata_q;
    assign mmio_wstrb     = wstrb_q;

endmodule

// File: tb/tb_picorv32_bus_router.sv
// Directed, table-driven bench for picorv32_bus_router with SRAM/MMIO responder models.
module tb_picorv32_bus_router;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        cpu_mem_valid = 1'b0;
    logic        cpu_mem_instr = 1'b0;
    logic [31:0] cpu_mem_addr = '0;
    logic [31:0] cpu_mem_wdata = '0;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;

    logic        sram_mem_valid;
    logic        sram_mem_instr;
    logic [16:0] sram_mem_addr;
    logic [31:0] sram_mem_wdata;
    logic [3:0]  sram_mem_wstrb;
    logic        sram_mem_ready;
    logic [31:0] sram_mem_rdata = '0;

    logic        mmio_valid;
    logic [11:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic        mmio_ready;
    logic [31:0] mmio_rdata = '0;

    logic        bus_err;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    picorv32_bus_router #(
        .SRAM_BASE      (32'h0000_0000),
        .SRAM_SIZE      (32'h0001_0000),
        .MMIO_BASE      (32'h1000_0000),
        .MMIO_SIZE      (32'h0000_1000),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cpu_mem_valid  (cpu_mem_valid),
        .cpu_mem_instr  (cpu_mem_instr),
        .cpu_mem_addr   (cpu_mem_addr),
        .cpu_mem_wdata  (cpu_mem_wdata),
        .cpu_mem_wstrb  (cpu_mem_wstrb),
        .cpu_mem_ready  (cpu_mem_ready),
        .cpu_mem_rdata  (cpu_mem_rdata),
        .sram_mem_valid (sram_mem_valid),
        .sram_mem_instr (sram_mem_instr),
        .sram_mem_addr  (sram_mem_addr),
        .sram_mem_wdata (sram_mem_wdata),
        .sram_mem_wstrb (sram_mem_wstrb),
        .sram_mem_ready (sram_mem_ready),
        .sram_mem_rdata (sram_mem_rdata),
        .mmio_valid     (mmio_valid),
        .mmio_addr      (mmio_addr),
        .mmio_wdata     (mmio_wdata),
        .mmio_wstrb     (mmio_wstrb),
        .mmio_ready     (mmio_ready),
        .mmio_rdata     (mmio_rdata),
        .bus_err        (bus_err),
        .err_addr       (err_addr)
    );

    // SRAM model: ready after sram_lat valid cycles; returns the pre-write word.
    logic [31:0] sram_mem [0:32767];
    logic        mem_load = 1'b0;
    int unsigned sram_lat = 1;
    int unsigned sram_seen = 0;
    logic        sram_resp_ready = 1'b0;
    logic        sram_force_ready = 1'b0;
    logic [16:0] last_sram_off = '0;
    logic        last_sram_instr = 1'b0;
    logic [31:0] sram_word;

    assign sram_mem_ready = sram_resp_ready | sram_force_ready;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32768; i++) sram_mem[i] <= 32'h0;
            sram_mem[16'h0004] <= 32'h1111_2222;
            sram_mem[16'h0008] <= 32'h5555_5555;
            sram_mem[16'h0010] <= 32'h1234_5678;
            sram_mem[16'h0011] <= 32'h00A0_0093;
            sram_mem[16'h3FFF] <= 32'hCAFE_F00D;
        end else if (sram_mem_valid && !sram_resp_ready) begin
            if (sram_seen + 1 >= sram_lat) begin
                sram_resp_ready <= 1'b1;
                sram_seen       <= 0;
                sram_word        = sram_mem[sram_mem_addr[16:2]];
                sram_mem_rdata  <= sram_word;
                last_sram_off   <= sram_mem_addr;
                last_sram_instr <= sram_mem_instr;
                for (int b = 0; b < 4; b++)
                    if (sram_mem_wstrb[b]) sram_word[8*b +: 8] = sram_mem_wdata[8*b +: 8];
                sram_mem[sram_mem_addr[16:2]] <= sram_word;
            end else begin
                sram_seen <= sram_seen + 1;
            end
        end else begin
            sram_resp_ready <= 1'b0;
            sram_seen       <= 0;
        end
    end

    // MMIO model: read data encodes the offset so address routing is visible in rdata.
    int unsigned mmio_lat = 1;
    int unsigned mmio_seen = 0;
    logic        mmio_resp_ready = 1'b0;
    logic [11:0] last_mmio_off = '0;
    logic [31:0] last_mmio_wdata = '0;
    logic [3:0]  last_mmio_wstrb = '0;

    assign mmio_ready = mmio_resp_ready;

    always @(posedge clk) begin
        if (mmio_valid && !mmio_resp_ready) begin
            if (mmio_seen + 1 >= mmio_lat) begin
                mmio_resp_ready <= 1'b1;
                mmio_seen       <= 0;
                mmio_rdata      <= 32'hC0DE_0000 | {20'h0, mmio_addr};
                last_mmio_off   <= mmio_addr;
                last_mmio_wdata <= mmio_wdata;
                last_mmio_wstrb <= mmio_wstrb;
            end else begin
                mmio_seen <= mmio_seen + 1;
            end
        end else begin
            mmio_resp_ready <= 1'b0;
            mmio_seen       <= 0;
        end
    end

    int unsigned n_sram_v = 0, n_mmio_v = 0, n_ready = 0, n_err = 0;
    always @(negedge clk) begin
        if (sram_mem_valid) n_sram_v <= n_sram_v + 1;
        if (mmio_valid)     n_mmio_v <= n_mmio_v + 1;
        if (cpu_mem_ready)  n_ready  <= n_ready + 1;
        if (bus_err)        n_err    <= n_err + 1;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic i, output logic [31:0] rd, output logic timed_out);
        @(posedge clk); #1;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = a;
        cpu_mem_wdata = d;
        cpu_mem_wstrb = s;
        cpu_mem_instr = i;
        timed_out = 1'b1;
        rd = '0;
        for (int unsigned n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (cpu_mem_ready) begin
                rd = cpu_mem_rdata;
                timed_out = 1'b0;
                break;
            end
        end
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = '0;
        cpu_mem_instr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          tgt;       // 0 none, 1 sram, 2 mmio
        logic [16:0] exp_off;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        to;
        logic [31:0] exp_err_addr;
        int unsigned s_sram, s_mmio, s_rdy, s_err;

        vecs[0]  = '{32'h0000_0040, 32'h0,         4'b0000, 1'b0, 32'h1234_5678, 1'b0, 1, 17'h00040};
        vecs[1]  = '{32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h1111_2222, 1'b0, 1, 17'h00010};
        vecs[2]  = '{32'h0000_0010, 32'h0,         4'b0000, 1'b0, 32'h1111_CCDD, 1'b0, 1, 17'h00010};
        vecs[3]  = '{32'h1000_0004, 32'hDEAD_BEEF, 4'b1010, 1'b0, 32'hC0DE_0004, 1'b0, 2, 17'h00004};
        vecs[4]  = '{32'h1000_0FFC, 32'h0,         4'b0000, 1'b0, 32'hC0DE_0FFC, 1'b0, 2, 17'h00FFC};
        vecs[5]  = '{32'h2000_0000, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b1, 0, 17'h0};
        vecs[6]  = '{32'h0000_FFFC, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 17'h0FFFC};
        vecs[7]  = '{32'h0001_0000, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b1, 0, 17'h0};
        vecs[8]  = '{32'h1000_1000, 32'h0102_0304, 4'b1111, 1'b0, 32'h0,         1'b1, 0, 17'h0};
        vecs[9]  = '{32'h0FFF_FFFC, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b1, 0, 17'h0};
        vecs[10] = '{32'h0000_0044, 32'h0,         4'b0000, 1'b1, 32'h00A0_0093, 1'b0, 1, 17'h00044};
        vecs[11] = '{32'h1000_0000, 32'h0,         4'b0000, 1'b0, 32'hC0DE_0000, 1'b0, 2, 17'h00000};

        mem_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        check("rst_cpu_ready", {31'b0, cpu_mem_ready}, 32'h0);
        check("rst_cpu_rdata", cpu_mem_rdata, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_sram_valid", {31'b0, sram_mem_valid}, 32'h0);
        check("rst_mmio_valid", {31'b0, mmio_valid}, 32'h0);
        check("rst_sram_addr", {15'b0, sram_mem_addr}, 32'h0);
        resetn = 1'b1;
        exp_err_addr = 32'h0;

        for (int unsigned v = 0; v < 12; v++) begin
            s_sram = n_sram_v; s_mmio = n_mmio_v; s_rdy = n_ready; s_err = n_err;
            xfer(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].instr, rd, to);
            if (vecs[v].exp_err) exp_err_addr = vecs[v].addr;
            check($sformatf("v%0d_timeout", v), {31'b0, to}, 32'h0);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("v%0d_ready_pulses", v), n_ready - s_rdy, 32'd1);
            check($sformatf("v%0d_err_pulses", v), n_err - s_err, {31'b0, vecs[v].exp_err});
            check($sformatf("v%0d_err_addr", v), err_addr, exp_err_addr);
            check($sformatf("v%0d_sram_access", v), {31'b0, n_sram_v != s_sram}, {31'b0, vecs[v].tgt == 1});
            check($sformatf("v%0d_mmio_access", v), {31'b0, n_mmio_v != s_mmio}, {31'b0, vecs[v].tgt == 2});
            check($sformatf("v%0d_rdata_hold", v), cpu_mem_rdata, vecs[v].exp_rdata);
            if (vecs[v].tgt == 1) begin
                check($sformatf("v%0d_sram_off", v), {15'b0, last_sram_off}, {15'b0, vecs[v].exp_off});
                check($sformatf("v%0d_sram_instr", v), {31'b0, last_sram_instr}, {31'b0, vecs[v].instr});
            end
            if (vecs[v].tgt == 2) begin
                check($sformatf("v%0d_mmio_off", v), {20'b0, last_mmio_off}, {15'b0, vecs[v].exp_off});
                check($sformatf("v%0d_mmio_wstrb", v), {28'b0, last_mmio_wstrb}, {28'b0, vecs[v].wstrb});
                check($sformatf("v%0d_mmio_wdata", v), last_mmio_wdata, vecs[v].wdata);
            end
        end

        // Back-to-back SRAM reads while the SRAM keeps ready high from the first one.
        xfer(32'h0000_0040, 32'h0, 4'b0000, 1'b0, rd, to);
        check("b2b_first_rdata", rd, 32'h1234_5678);
        sram_force_ready = 1'b1;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0000_0010;
        cpu_mem_wstrb = 4'b0000;
        s_sram = n_sram_v;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_valid_held_off", n_sram_v - s_sram, 32'd0);
        check("b2b_no_early_ready", {31'b0, cpu_mem_ready}, 32'h0);
        sram_force_ready = 1'b0;
        to = 1'b1;
        for (int unsigned n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (cpu_mem_ready) begin
                to = 1'b0;
                break;
            end
        end
        check("b2b_second_timeout", {31'b0, to}, 32'h0);
        check("b2b_second_rdata", cpu_mem_rdata, 32'h1111_CCDD);
        check("b2b_second_valid_seen", {31'b0, n_sram_v != s_sram}, 32'h1);
        cpu_mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // MMIO never ready: timeout after 255 valid cycles.
        mmio_lat = 100000;
        s_mmio = n_mmio_v; s_err = n_err;
        xfer(32'h1000_0008, 32'h0, 4'b0000, 1'b0, rd, to);
        check("tmo_completed", {31'b0, to}, 32'h0);
        check("tmo_rdata", rd, 32'h0);
        check("tmo_err_pulses", n_err - s_err, 32'd1);
        check("tmo_err_addr", err_addr, 32'h1000_0008);
        check("tmo_valid_cycles", n_mmio_v - s_mmio, 32'd255);

        // Ready arriving in the last counted cycle wins over the timeout.
        mmio_lat = 254;
        s_err = n_err;
        xfer(32'h1000_000C, 32'h0, 4'b0000, 1'b0, rd, to);
        check("edge254_rdata", rd, 32'hC0DE_000C);
        check("edge254_err_pulses", n_err - s_err, 32'd0);
        check("edge254_err_addr_held", err_addr, 32'h1000_0008);

        mmio_lat = 255;
        s_err = n_err;
        xfer(32'h1000_0010, 32'h0, 4'b0000, 1'b0, rd, to);
        check("edge255_rdata", rd, 32'h0);
        check("edge255_err_pulses", n_err - s_err, 32'd1);
        check("edge255_err_addr", err_addr, 32'h1000_0010);
        mmio_lat = 1;

        // Reset in the middle of a slow SRAM write aborts it.
        sram_lat = 50;
        @(posedge clk); #1;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0000_0020;
        cpu_mem_wdata = 32'hFFFF_FFFF;
        cpu_mem_wstrb = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_valid_before", {31'b0, sram_mem_valid}, 32'h1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rstmid_sram_valid", {31'b0, sram_mem_valid}, 32'h0);
        check("rstmid_cpu_ready", {31'b0, cpu_mem_ready}, 32'h0);
        check("rstmid_cpu_rdata", cpu_mem_rdata, 32'h0);
        check("rstmid_err_addr", err_addr, 32'h0);
        check("rstmid_sram_addr", {15'b0, sram_mem_addr}, 32'h0);
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = '0;
        resetn = 1'b1;
        s_sram = n_sram_v; s_rdy = n_ready;
        repeat (60) @(posedge clk);
        #1;
        check("rstmid_no_valid_after", n_sram_v - s_sram, 32'd0);
        check("rstmid_no_ready_after", n_ready - s_rdy, 32'd0);
        check("rstmid_mem_untouched", sram_mem[8], 32'h5555_5555);
        sram_lat = 1;
        xfer(32'h0000_0040, 32'h0, 4'b0000, 1'b0, rd, to);
        check("post_rst_rdata", rd, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/picorv32_bus_router.md
PICORV32_BUS_ROUTER -- requirements
Module: picorv32_bus_router

Interface
REQ-001 SHALL have parameter SRAM_BASE, default 32'h0000_0000, SRAM window base byte address.
REQ-002 SHALL have parameter SRAM_SIZE, default 32'h0001_0000, SRAM window size in bytes (power of two).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h1000_0000, MMIO window base byte address.
REQ-004 SHALL have parameter MMIO_SIZE, default 32'h0000_1000, MMIO window size in bytes (power of two).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait cycles for a target ready.
REQ-006 SHALL have ports: clk in 1 clock; resetn in 1 reset, synchronous, active-low.
REQ-007 SHALL have ports: cpu_mem_valid in 1; cpu_mem_instr in 1; cpu_mem_addr in 32; cpu_mem_wdata in 32; cpu_mem_wstrb in 4; cpu_mem_ready out 1; cpu_mem_rdata out 32 (PicoRV32 native bus).
REQ-008 SHALL have ports: sram_mem_valid out 1; sram_mem_instr out 1; sram_mem_addr out 17 (byte offset); sram_mem_wdata out 32; sram_mem_wstrb out 4; sram_mem_ready in 1; sram_mem_rdata in 32.
REQ-009 SHALL have ports: mmio_valid out 1; mmio_addr out 12 (byte offset); mmio_wdata out 32; mmio_wstrb out 4; mmio_ready in 1; mmio_rdata in 32.
REQ-010 SHALL have ports: bus_err out 1 (one-cycle pulse); err_addr out 32 (address of last failed access).

Function
REQ-011 SHALL implement FSM states IDLE, SRAM_REQ, MMIO_REQ, DONE.
REQ-012 In IDLE with cpu_mem_valid=1, SHALL latch addr/wdata/wstrb/instr and decode: in-window means BASE <= addr < BASE+SIZE.
REQ-013 SRAM hit -> SRAM_REQ; MMIO hit -> MMIO_REQ; unmapped -> DONE with rdata 0, bus_err=1 that cycle+1, err_addr=addr, no target access.
REQ-014 Target offsets SHALL be addr-BASE truncated to target width; wdata/wstrb/instr forwarded unchanged from latches.
REQ-015 Target valid SHALL be registered, asserted only while in *_REQ and only once the target's ready has been sampled low (stale-ready drain).
REQ-016 Target valid SHALL stay high, inputs stable, until target ready=1 is sampled; then rdata captured, valid deasserted next edge, state -> DONE.
REQ-017 In DONE, cpu_mem_ready SHALL be 1 for exactly one cycle with captured rdata, then -> IDLE.
REQ-018 IDLE SHALL not sample cpu_mem_valid in the cycle cpu_mem_ready was high; one transaction in flight max.
REQ-019 Timeout counter SHALL clear on entry to *_REQ, count each cycle without ready; at TIMEOUT_CYCLES: drop valid, rdata=32'h0, bus_err pulse, err_addr=addr, -> DONE.
REQ-020 Ready and timeout reached in same cycle: ready wins, no error.
REQ-021 Write to unmapped address SHALL be dropped but still completed (ready pulse) with bus_err.
REQ-022 cpu_mem_rdata SHALL hold its value between transactions; err_addr holds until next error.

Reset
REQ-023 On resetn=0 at posedge: state IDLE, all valid/ready/bus_err 0, cpu_mem_rdata 0, err_addr 0, counter 0, latches 0.
REQ-024 Reset mid-transaction SHALL abort it immediately; no target write completes afterwards from this block.

Structure
REQ-025 Package picorv32_bus_pkg SHALL hold the FSM state type and default window base/size constants.
REQ-026 Sub-module picorv32_addr_decode (combinational, addr -> hit_sram/hit_mmio/offset) is natural; FSM, timeout, latches stay in top.

Verification
REQ-027 Read SRAM 0x0000_0040 holding 0x1234_5678 -> sram_mem_addr=0x040, cpu_mem_rdata=0x1234_5678, one ready pulse.
REQ-028 Write 0x0000_0010 wdata 0xAABB_CCDD wstrb 4'b0011, readback -> 0x????_CCDD low half updated only.
REQ-029 Write MMIO 0x1000_0004 -> mmio_addr=0x004, mmio_wstrb forwarded; SRAM valid stays 0.
REQ-030 Read 0x2000_0000 -> rdata 0, bus_err pulse, err_addr=0x2000_0000, no target valid.
REQ-031 mmio_ready tied 0 -> completion after 255 wait cycles, rdata 0, bus_err pulse.
REQ-032 Back-to-back SRAM reads with stale sram_mem_ready high -> second valid waits for ready low; both rdata correct; resetn low mid-read -> IDLE, valids 0.
